// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - oversampled UART receiver with error-flagged output FIFO
// Build option: define UART_RX_PARITY_EN to expect a parity bit between data and stop.
// Ports:
//   uart_samplig_clk  sampling clock, OVERSAMPLE x baud
//   reset             synchronous, active-high
//   RsRx              serial line, idle high, already synchronised
//   valid / ready     head-entry handshake (pop on valid && ready)
//   received_data     head entry data
//   frame_err         head entry stop bit was 0
//   parity_err        head entry parity mismatch (0 without UART_RX_PARITY_EN)
//   overrun           one-cycle pulse when a finished frame is dropped on a full FIFO
//   fifo_count        entries held
module uart_rx_buffered #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                        uart_samplig_clk,
    input  logic                        reset,
    input  logic                        RsRx,
    output logic                        valid,
    input  logic                        ready,
    output logic [DATA_BITS-1:0]        received_data,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CW   = $clog2(OVERSAMPLE);
    localparam int BW   = $clog2(DATA_BITS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
`ifdef UART_RX_PARITY_EN
    localparam int EW   = DATA_BITS + 2;   // {data, frame_err, parity_err}
`else
    localparam int EW   = DATA_BITS + 1;   // {data, frame_err}
`endif

    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || OVERSAMPLE > 32 ||
        (OVERSAMPLE % 2) != 0 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_buffered: illegal parameter value");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t                 state, state_n;
    logic [CW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   tick_clr;
    logic                   start_det;
    logic                   bit_sample;
    logic                   stop_sample;
    logic [EW-1:0]          push_entry;

    // ---------------- receive FSM ----------------
    always_ff @(posedge uart_samplig_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_sample;
    logic par_bad;
`endif

    always_comb begin
        state_n     = state;
        tick_clr    = 1'b0;
        start_det   = 1'b0;
        bit_sample  = 1'b0;
        stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_sample = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!RsRx) begin
                    start_det = 1'b1;
                    tick_clr  = 1'b1;
                    state_n   = START;
                end
            end
            START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (tick_cnt == HALF_M1) begin
                    tick_clr = 1'b1;
                    state_n  = RsRx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_cnt == FULL_M1) begin
                    tick_clr   = 1'b1;
                    bit_sample = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_cnt == FULL_M1) begin
                    tick_clr      = 1'b1;
                    parity_sample = 1'b1;
                    state_n       = STOP;
                end
            end
`endif
            STOP: begin
                if (tick_cnt == FULL_M1) begin
                    tick_clr    = 1'b1;
                    stop_sample = 1'b1;
                    // A low stop bit parks in BREAK so a held-low line yields one entry.
                    state_n     = RsRx ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (RsRx) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------- receive datapath ----------------
    always_ff @(posedge uart_samplig_clk) begin
        if (reset) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            tick_cnt <= tick_clr ? '0 : tick_cnt + CW'(1);
            if (start_det) begin
                bit_cnt <= '0;
            end else if (bit_sample) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (bit_sample) begin
                shift_reg <= {RsRx, shift_reg[DATA_BITS-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic expected_par;
    assign expected_par = (^shift_reg) ^ (PARITY_ODD != 0);

    always_ff @(posedge uart_samplig_clk) begin
        if (reset) begin
            par_bad <= 1'b0;
        end else if (start_det) begin
            par_bad <= 1'b0;
        end else if (parity_sample) begin
            par_bad <= (RsRx != expected_par);
        end
    end

    assign push_entry = {shift_reg, ~RsRx, par_bad};
`else
    assign push_entry = {shift_reg, ~RsRx};
`endif

    // ---------------- output FIFO ----------------
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [EW-1:0]   head_entry;
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
    logic [CNTW-1:0] count_n;
    logic            full, pop, push_ok, drop;

    assign valid   = (fifo_count != '0);
    assign full    = (fifo_count == CNTW'(FIFO_DEPTH));
    assign pop     = valid && ready;
    assign push_ok = stop_sample && (!full || pop);
    assign drop    = stop_sample && full && !pop;

    always_comb begin
        rd_ptr_n = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_n  = fifo_count;
        case ({push_ok, pop})
            2'b10:   count_n = fifo_count + CNTW'(1);
            2'b01:   count_n = fifo_count - CNTW'(1);
            default: count_n = fifo_count;
        endcase
    end

    always_ff @(posedge uart_samplig_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge uart_samplig_clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            head_entry <= '0;
            overrun    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_ptr_n;
            fifo_count <= count_n;
            overrun    <= drop;
            // Head register tracks the next read slot; when that slot is being
            // written this cycle the incoming entry is forwarded around the RAM.
            if (count_n != '0) begin
                head_entry <= (push_ok && (wr_ptr == rd_ptr_n)) ? push_entry : mem[rd_ptr_n];
            end
        end
    end

    assign received_data = head_entry[EW-1 -: DATA_BITS];
    assign frame_err     = head_entry[EW-DATA_BITS-1];
`ifdef UART_RX_PARITY_EN
    assign parity_err    = head_entry[0];
`else
    assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb/tb_uart_rx_buffered.sv - randomized self-checking bench for uart_rx_buffered
module tb_uart_rx_buffered;

    localparam int DB    = 8;
    localparam int OS    = 16;
    localparam int DEPTH = 4;
    localparam int ODD   = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PAR   = 1;
`else
    localparam int PAR   = 0;
`endif
    localparam int PUSH_OFS = OS / 2 + (DB + 1) * OS + PAR * OS;
    localparam int EW = DB + 2;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          RsRx  = 1'b1;
    logic          ready = 1'b0;
    logic          valid;
    logic [DB-1:0] received_data;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .FIFO_DEPTH(DEPTH),
        .PARITY_ODD(ODD)
    ) dut (
        .uart_samplig_clk(clk),
        .reset           (reset),
        .RsRx            (RsRx),
        .valid           (valid),
        .ready           (ready),
        .received_data   (received_data),
        .frame_err       (frame_err),
        .parity_err      (parity_err),
        .overrun         (overrun),
        .fifo_count      (fifo_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer-side monitor, sampled on the falling edge.
    logic [EW-1:0] got_q[$];
    logic [EW-1:0] exp_q[$];
    int   beats = 0, ovr_pulses = 0, rise_cyc = -1, unstable = 0;
    logic prev_hold = 1'b0, prev_valid = 1'b0;
    logic [EW-1:0] prev_head = '0;
    bit   rand_ready = 1'b0;

    always @(negedge clk) begin
        if (valid && ready) begin
            got_q.push_back({received_data, frame_err, parity_err});
            beats++;
        end
        if (overrun) ovr_pulses++;
        if (valid && !prev_valid) rise_cyc = cyc;
        if (prev_hold && valid && ({received_data, frame_err, parity_err} !== prev_head)) unstable++;
        prev_hold  = valid && !ready;
        prev_head  = {received_data, frame_err, parity_err};
        prev_valid = valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    // Reference: a frame's entry follows from what was put on the wire.
    function automatic logic [EW-1:0] model(input logic [DB-1:0] d, input logic stop_bit,
                                            input logic pbit);
        logic pe;
        pe = 1'b0;
        if (PAR != 0) pe = ((($countones(d) + int'(pbit)) % 2) != ODD);
        return {d, ~stop_bit, pe};
    endfunction

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit,
                              input logic par_flip, output int t0);
        logic pbit;
        pbit = 1'(($countones(d) + ODD) % 2) ^ par_flip;
        RsRx = 1'b0;
        t0   = cyc + 1;
        repeat (OS) tick();
        for (int i = 0; i < DB; i++) begin
            RsRx = d[i];
            repeat (OS) tick();
        end
        if (PAR != 0) begin
            RsRx = pbit;
            repeat (OS) tick();
        end
        RsRx = stop_bit;
        repeat (OS) tick();
        RsRx = 1'b1;
        exp_q.push_back(model(d, stop_bit, pbit));
    endtask

    task automatic drain();
        ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!valid && fifo_count == 0) break;
            tick();
        end
        tick();
    endtask

    task automatic compare_queues(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_entry%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int t0;
        logic [DB-1:0] d;

        // Reset state
        repeat (3) tick();
        check("rst_valid", valid, 0);
        check("rst_data", received_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_count", fifo_count, 0);
        reset = 1'b0;
        repeat (2 * OS) tick();

        // Single frame 0xA5 with ready held high
        got_q.delete(); exp_q.delete();
        ready = 1'b1; beats = 0; rise_cyc = -1;
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        repeat (2 * OS) tick();
        check("a5_valid_rise_cycle", rise_cyc, t0 + PUSH_OFS);
        check("a5_beats", beats, 1);
        compare_queues("a5");
        check("a5_count_after", fifo_count, 0);
        check("a5_valid_after", valid, 0);

        // False start: line low for 4 ticks only
        got_q.delete(); exp_q.delete(); beats = 0;
        RsRx = 1'b0;
        repeat (4) tick();
        RsRx = 1'b1;
        repeat (2 * OS) tick();
        check("false_start_beats", beats, 0);
        check("false_start_valid", valid, 0);
        check("false_start_count", fifo_count, 0);
        send_frame(8'h4E, 1'b1, 1'b0, t0);
        drain();
        compare_queues("after_false_start");

        // Stop bit 0 followed by a held-low line
        got_q.delete(); exp_q.delete(); beats = 0;
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        RsRx = 1'b0;
        repeat (40) tick();
        check("break_beats_low", beats, 1);
        RsRx = 1'b1;
        repeat (2 * OS) tick();
        check("break_beats_high", beats, 1);
        send_frame(8'h96, 1'b1, 1'b0, t0);
        drain();
        compare_queues("break");

        // Overrun: five frames into a four-deep FIFO with no consumer
        got_q.delete(); exp_q.delete(); ovr_pulses = 0; unstable = 0;
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(DB'(i), 1'b1, 1'b0, t0);
        repeat (OS) tick();
        check("ovr_pulses", ovr_pulses, 1);
        check("ovr_count", fifo_count, DEPTH);
        check("ovr_valid", valid, 1);
        check("ovr_head", received_data, 8'h01);
        void'(exp_q.pop_back());
        drain();
        compare_queues("ovr");
        check("ovr_head_stable", unstable, 0);

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 has three ones; even parity wants a 1
        got_q.delete(); exp_q.delete();
        ready = 1'b1;
        send_frame(8'h07, 1'b1, 1'b1, t0);
        send_frame(8'h07, 1'b1, 1'b0, t0);
        drain();
        compare_queues("parity");
        check("parity_bad_flag", got_q.size() > 0 ? 32'(got_q[0][0]) : 32'hDEAD, 1);
        check("parity_good_flag", got_q.size() > 1 ? 32'(got_q[1][0]) : 32'hDEAD, 0);
`endif

        // Reset during data bit 3 with an entry already queued
        got_q.delete(); exp_q.delete();
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, t0);
        repeat (OS) tick();
        d = 8'hC3;
        RsRx = 1'b0;
        repeat (OS) tick();
        for (int i = 0; i < 3; i++) begin
            RsRx = d[i];
            repeat (OS) tick();
        end
        RsRx = d[3];
        repeat (5) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("mid_rst_valid", valid, 0);
        check("mid_rst_data", received_data, 0);
        check("mid_rst_frame_err", frame_err, 0);
        check("mid_rst_parity_err", parity_err, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_count", fifo_count, 0);
        reset = 1'b0;
        RsRx  = 1'b1;
        repeat (2 * OS) tick();
        got_q.delete(); exp_q.delete();
        ready = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0, t0);
        drain();
        compare_queues("post_rst");

        // Randomized frames, gaps, stop bits and consumer stalls
        got_q.delete(); exp_q.delete(); unstable = 0;
        rand_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            send_frame(DB'($urandom), ($urandom_range(0, 3) != 0),
                       (PAR != 0) ? 1'($urandom_range(0, 1)) : 1'b0, t0);
            repeat ($urandom_range(1, 20)) tick();
        end
        rand_ready = 1'b0;
        drain();
        compare_queues("rand");
        check("rand_head_stable", unstable, 0);
        check("rand_count_end", fifo_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Parametrised UART receiver with a frame-error/parity checker and an output FIFO. It is the successor to the single-byte receiver and sits between the `RsRx` pin and the command decoder. Serial frames are oversampled on the UART sampling clock, checked, and queued with per-entry error flags. Entries are presented over a valid/ready handshake, so back-to-back frames survive a slow consumer.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5..9; sent LSB first.
- `OVERSAMPLE`, 16: sampling-clock ticks per bit; even, 8..32.
- `FIFO_DEPTH`, 4: entries; power of two, ≥2.
- `PARITY_ODD`, 0: with parity compiled in, 0 = even, 1 = odd.
- `uart_samplig_clk` in 1: sampling clock, `OVERSAMPLE` × baud; single clock domain.
- `reset` in 1: synchronous, active-high.
- `RsRx` in 1: serial line, idle high; assumed already synchronised upstream.
- `valid` out 1: FIFO non-empty.
- `ready` in 1: consumer accepts the head entry.
- `received_data` out `DATA_BITS`: head entry data.
- `frame_err` out 1: head entry had stop bit = 0.
- `parity_err` out 1: head entry parity mismatch; constant 0 when parity is compiled out.
- `overrun` out 1: one-cycle pulse when a completed frame is dropped because the FIFO is full.
- `fifo_count` out $clog2(`FIFO_DEPTH`)+1: entries held.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only when compiled in), STOP, BREAK.
- IDLE: when `RsRx` = 0 is sampled, go to START and load tick counter 0.
- START: at tick `OVERSAMPLE`/2−1, sample the line.
  - If 1: false start; return to IDLE with no push.
  - Else: clear the counter and go to DATA.
- DATA: sample every `OVERSAMPLE` ticks into a shift register, LSB first. The bit counter runs 0..`DATA_BITS`−1.
- PARITY: sample one bit. Mismatch against the XOR of the data bits (inverted if `PARITY_ODD`) sets the parity flag.
- STOP: sample one bit, then push {data, frame_err, parity_err} into the FIFO.
  - Stop = 1: go to IDLE on the same edge. The next start bit may begin on the following tick.
  - Stop = 0: go to BREAK.
- BREAK: wait for `RsRx` = 1, then go to IDLE. A held-low line produces exactly one frame_err entry.
- FIFO behaviour:
  - Push when not full.
  - Push when full with a simultaneous pop: the push is accepted.
  - Push when full with no pop: the frame is dropped, the FIFO is unchanged, and `overrun` pulses.
  - Pop occurs on `valid` && `ready`. `ready` while empty is ignored.
- Head outputs (`received_data`, `frame_err`, `parity_err`) are registered from the read pointer and are stable while `valid` = 1 and `ready` = 0.
- Pointers wrap modulo `FIFO_DEPTH`. `fifo_count` saturates at `FIFO_DEPTH` by construction.

## Timing
- t0 is the edge on which IDLE samples `RsRx` = 0.
  - Start check at t0 + `OVERSAMPLE`/2.
  - Data bit i is sampled at t0 + `OVERSAMPLE`/2 + (i+1)·`OVERSAMPLE`.
  - Parity, when present, is sampled at the next `OVERSAMPLE` boundary; stop at the one after that.
- The push happens on the stop-sample edge. `valid` rises one cycle later when the FIFO was empty.
- Push and pop in the same cycle leave `fifo_count` unchanged.
- Reset: FSM to IDLE; counters, pointers, and the shift register cleared.
  - Outputs after reset: `valid` = 0, `received_data` = 0, `frame_err` = 0, `parity_err` = 0, `overrun` = 0, `fifo_count` = 0.
  - A partial frame in progress at reset is discarded.

## Configuration
- `UART_RX_PARITY_EN` defined: a parity bit is expected between the data bits and the stop bit. PARITY state is present and `PARITY_ODD` applies.
- `UART_RX_PARITY_EN` not defined: no parity bit and no PARITY state. Stop is sampled directly after the last data bit, and `parity_err` is tied to 0.

## Test plan
- Default parameters, parity off, frame 0xA5, `ready` = 1 → exactly one `valid` beat with data 0xA5, `frame_err` = 0, `fifo_count` returns to 0.
- `RsRx` low for 4 ticks, then high → no push, FSM back in IDLE, `valid` stays 0.
- Frame 0x3C with stop = 0, line then held low 40 ticks → one entry with data 0x3C and `frame_err` = 1. No further entries until the line goes high and a new start bit arrives.
- `ready` = 0, five back-to-back frames 0x01..0x05, `FIFO_DEPTH` = 4 → `overrun` pulses once on the fifth stop edge and `fifo_count` = 4. Raising `ready` then yields 0x01, 0x02, 0x03, 0x04 in order.
- `UART_RX_PARITY_EN`, `PARITY_ODD` = 0, data 0x07 with parity bit 0 → `parity_err` = 1. The same frame with parity bit 1 → `parity_err` = 0.
- `reset` asserted during data bit 3, then a clean 0x5A frame → all outputs 0 after reset, then a single entry 0x5A with no errors.
